// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution MAC controller.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } conv_state_t;

  // Memory read register plus MAC product register.
  localparam int DRAIN_CYCLES = 2;

  function automatic int max1(input int v);
    return (v > 1) ? v : 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Output-pixel and filter-tap counters with the image/filter address arithmetic.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int N   = 8,
  parameter int K   = 3,
  parameter int XAW = $clog2(N*N),
  parameter int WAW = $clog2(K*K),
  parameter int PW  = max1($clog2(N-K+1))
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  input  logic           advance_pixel,
  input  logic           addr_en,
  output logic [XAW-1:0] x_addr,
  output logic [WAW-1:0] w_addr,
  output logic [PW-1:0]  row,
  output logic [PW-1:0]  col,
  output logic           last_tap,
  output logic           last_pixel
);

  localparam int KW = max1($clog2(K));
  localparam logic [KW-1:0] K_LAST = KW'(K-1);
  localparam logic [PW-1:0] P_LAST = PW'(N-K);

  logic [KW-1:0] ki_q, ki_d, kj_q, kj_d;
  logic [PW-1:0] row_q, row_d, col_q, col_d;
  logic [XAW-1:0] x_lin_s;
  logic [WAW-1:0] w_lin_s;

  // Next-state of the tap and pixel counters; both wrap so a finished run leaves them at zero.
  always_comb begin
    ki_d  = ki_q;
    kj_d  = kj_q;
    row_d = row_q;
    col_d = col_q;
    if (step) begin
      if (kj_q == K_LAST) begin
        kj_d = '0;
        ki_d = (ki_q == K_LAST) ? '0 : ki_q + KW'(1);
      end else begin
        kj_d = kj_q + KW'(1);
      end
    end else begin
      kj_d = kj_q;
    end
    if (advance_pixel) begin
      if (col_q == P_LAST) begin
        col_d = '0;
        row_d = (row_q == P_LAST) ? '0 : row_q + PW'(1);
      end else begin
        col_d = col_q + PW'(1);
      end
    end else begin
      col_d = col_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ki_q  <= '0;
      kj_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ki_q  <= ki_d;
      kj_q  <= kj_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Addresses are forced to zero outside the issue window.
  always_comb begin
    x_lin_s    = (XAW'(row_q) + XAW'(ki_q)) * XAW'(N) + XAW'(col_q) + XAW'(kj_q);
    w_lin_s    = WAW'(ki_q) * WAW'(K) + WAW'(kj_q);
    x_addr     = addr_en ? x_lin_s : '0;
    w_addr     = addr_en ? w_lin_s : '0;
    row        = row_q;
    col        = col_q;
    last_tap   = (ki_q == K_LAST) && (kj_q == K_LAST);
    last_pixel = (row_q == P_LAST) && (col_q == P_LAST);
  end

endmodule

// File: rtl/conv_mac_ctrl.sv
// Sequencer driving an external MAC over a valid (no padding) 2-D convolution.
// Define CONV_MAC_CTRL_RELU_EN to clamp negative results to zero.
module conv_mac_ctrl
  import conv_pkg::*;
#(
  parameter int N    = 8,
  parameter int K    = 3,
  parameter int OUTW = 64,
  localparam int XAW = $clog2(N*N),
  localparam int WAW = $clog2(K*K),
  localparam int PW  = max1($clog2(N-K+1))
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [XAW-1:0]         x_addr,
  output logic [WAW-1:0]         w_addr,
  output logic                   mac_init_acc,
  output logic                   mac_input_valid,
  input  logic signed [OUTW-1:0] mac_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OUTW-1:0] out_data,
  output logic [PW-1:0]          out_row,
  output logic [PW-1:0]          out_col
);

  conv_state_t state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic        issue_q, issue_d;
  logic        step_s, adv_s, last_tap_s, last_pixel_s;
  logic [PW-1:0] row_s, col_s;
  logic signed [OUTW-1:0] res_s;

  conv_addr_gen #(.N(N), .K(K), .XAW(XAW), .WAW(WAW), .PW(PW)) u_addr (
    .clk          (clk),
    .reset        (reset),
    .step         (step_s),
    .advance_pixel(adv_s),
    .addr_en      (state_q == ST_MAC),
    .x_addr       (x_addr),
    .w_addr       (w_addr),
    .row          (row_s),
    .col          (col_s),
    .last_tap     (last_tap_s),
    .last_pixel   (last_pixel_s)
  );

  // Control sequencing.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    step_s  = 1'b0;
    adv_s   = 1'b0;
    issue_d = (state_q == ST_MAC);
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_INIT;
        else       state_d = ST_IDLE;
      end
      ST_INIT: state_d = ST_MAC;
      ST_MAC: begin
        step_s = 1'b1;
        if (last_tap_s) begin
          state_d = ST_DRAIN;
          drain_d = 2'd0;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = ST_OUT;
          drain_d = 2'd0;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          adv_s   = 1'b1;
          state_d = last_pixel_s ? ST_DONE : ST_INIT;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, drain counter and the one-cycle-delayed issue flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      drain_q <= 2'd0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      issue_q <= issue_d;
    end
  end

  // The accumulator is final from the first OUT cycle and frozen while waiting.
  always_comb begin
`ifdef CONV_MAC_CTRL_RELU_EN
    res_s = mac_out[OUTW-1] ? '0 : mac_out;
`else
    res_s = mac_out;
`endif
    busy            = (state_q != ST_IDLE);
    done            = (state_q == ST_DONE);
    mac_init_acc    = (state_q == ST_INIT);
    mac_input_valid = issue_q;
    out_valid       = (state_q == ST_OUT);
    out_data        = (state_q == ST_OUT) ? res_s : '0;
    out_row         = row_s;
    out_col         = col_s;
  end

endmodule
